alu_pwr_ctrl: RTL and testbench
===============================

# alu_pwr_ctrl

Power-sequencing controller for the gated ALU domain. It drives the ALU's `alu_pwr_en`, `iso_en`, `save` and `restore` controls in a fixed, glitch-free order, so that a sleep request retains the ALU result in the always-on save register before isolation and power-off. A wake request restores that result after the power ramp. It also gates upstream `start` issue through `op_gnt`, so no operation reaches an unpowered, isolated or busy ALU.

## Interface
- `RAMP_CYCLES`, default 4: cycles spent in PWR_UP after `alu_pwr_en` rises and before `restore`; legal range 1..255.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sleep_req`  in  1  level request to power the ALU domain down.
- `op_req`  in  1  upstream has an ALU operation pending; wakes the domain and blocks sleep.
- `alu_busy`  in  1  `busy` from the ALU; only meaningful in ON.
- `alu_pwr_en`  out  1  ALU domain power enable.
- `iso_en`  out  1  output isolation enable.
- `save`  out  1  one-cycle pulse that loads the AON retention register.
- `restore`  out  1  one-cycle pulse that selects retained data during power-up.
- `op_gnt`  out  1  upstream may assert `start` this cycle.
- `pwr_state`  out  3  current FSM state encoding, for debug/status.

## Operation
- Moore FSM with a registered state. All control outputs are decoded from the state register only, so they are glitch-free.
- States and their outputs (`alu_pwr_en`/`iso_en`/`save`/`restore`):
  - ON: 1/0/0/0
  - SAVE: 1/0/1/0
  - ISO: 1/1/0/0
  - OFF: 0/1/0/0
  - PWR_UP: 1/1/0/0
  - RESTORE: 1/1/0/1
- Transitions:
  - ON -> SAVE when `sleep_req && !op_req && !alu_busy`; otherwise stay in ON.
  - SAVE -> ISO, unconditional after 1 cycle.
  - ISO -> OFF, unconditional after 1 cycle.
  - OFF -> PWR_UP when `op_req || !sleep_req`. On entry, load the ramp counter with `RAMP_CYCLES-1`.
  - PWR_UP: decrement the counter each cycle; go to RESTORE in the cycle the counter is 0.
  - RESTORE -> ON, unconditional after 1 cycle.
- `op_gnt = (state==ON) && !alu_busy && !(sleep_req && !op_req)`. The last term means a sleep decision closes the grant in the same cycle.
- Priority: `op_req` beats `sleep_req` in ON. Once the FSM leaves ON, the down-sequence SAVE->ISO->OFF always completes; there is no abort mid-sequence.
- Once PWR_UP is entered, it always completes through RESTORE to ON, even if `sleep_req` re-asserts. Sleep is then re-evaluated in ON.
- `alu_busy` is ignored outside ON.
- Ramp counter is 8 bits and saturates at 0; it never wraps.
- Encoding: ON=0, SAVE=1, ISO=2, OFF=3, PWR_UP=4, RESTORE=5. Codes 6/7 are illegal and recover to ON on the next clock.

## Timing
- Reset values: state ON, `alu_pwr_en`=1, `iso_en`=0, `save`=0, `restore`=0, `pwr_state`=0. `op_gnt` follows `!alu_busy && !(sleep_req && !op_req)`.
- `rst_n` asserted in any state forces ON asynchronously. The domain is assumed repowered with its own reset.
- Sleep: condition true at edge t gives SAVE for cycle t+1, ISO for t+2, and OFF from t+3. `iso_en` therefore rises one cycle before `alu_pwr_en` falls.
- Wake: condition true in OFF at edge t gives PWR_UP from t+1 for `RAMP_CYCLES` cycles, then RESTORE for one cycle, then ON. `iso_en` falls and `op_gnt` can rise `RAMP_CYCLES+2` cycles after t.
- Minimum sleep round trip: 3 cycles down + `RAMP_CYCLES+2` cycles up.
- `save` and `restore` are each exactly one cycle wide and are never high simultaneously.

## Structure
- Shared package `alu_pwr_pkg` holds:
  - the state enum/localparams (ON..RESTORE);
  - the `PWR_STATE_W`=3 constant;
  - the `RAMP_W`=8 constant.
- Sub-module `alu_pwr_ramp_cnt` (load/decrement/zero flag) is natural; everything else stays in one FSM file.

## Test plan
- Reset with `sleep_req`=0 -> outputs 1/0/0/0; `op_gnt`=1 when `alu_busy`=0; `pwr_state`=0.
- `sleep_req`=1, `alu_busy`=1 for 5 cycles, then 0 -> SAVE one cycle after busy drops. `save` is a single pulse, then ISO, then OFF with `alu_pwr_en`=0 and `iso_en`=1.
- In OFF with `RAMP_CYCLES`=4, pulse `op_req` while `sleep_req` stays 1 -> PWR_UP for exactly 4 cycles, then a `restore` pulse, then ON 6 cycles after the request with `iso_en`=0.
- In ON, `sleep_req`=1 and `op_req`=1 together -> stays ON, `op_gnt`=1. When `op_req` drops, SAVE follows on the next cycle.
- `sleep_req` toggled during SAVE/ISO -> sequence still reaches OFF. `sleep_req`=1 during PWR_UP -> still reaches ON first, then re-sleeps.
- Assert `rst_n`=0 mid-PWR_UP -> immediately ON with 1/0/0/0, and no `restore` pulse afterwards.

Source files
------------

// File: rtl/alu_pwr_pkg.sv
// -----------------------------------------------------------------------------
// alu_pwr_pkg
// Shared definitions for the ALU power-sequencing controller: state encoding,
// widths and the state-to-control decode used by the FSM.
// -----------------------------------------------------------------------------
package alu_pwr_pkg;

   localparam int PWR_STATE_W = 3;
   localparam int RAMP_W      = 8;

   // Codes 6 and 7 are unused and recover to ST_ON.
   typedef enum logic [PWR_STATE_W-1:0] {
      ST_ON      = 3'd0,
      ST_SAVE    = 3'd1,
      ST_ISO     = 3'd2,
      ST_OFF     = 3'd3,
      ST_PWR_UP  = 3'd4,
      ST_RESTORE = 3'd5
   } pwr_state_e;

   // Control bundle driven towards the gated ALU domain.
   typedef struct packed {
      logic pwr_en;
      logic iso_en;
      logic save;
      logic restore;
   } pwr_ctrl_t;

   localparam pwr_ctrl_t CTRL_ON = '{pwr_en: 1'b1, iso_en: 1'b0, save: 1'b0, restore: 1'b0};

   // Moore decode: controls depend on the state alone.
   function automatic pwr_ctrl_t decode_ctrl(input pwr_state_e st);
      pwr_ctrl_t c;
      c = CTRL_ON;
      case (st)
         ST_ON:      c = CTRL_ON;
         ST_SAVE:    c = '{pwr_en: 1'b1, iso_en: 1'b0, save: 1'b1, restore: 1'b0};
         ST_ISO:     c = '{pwr_en: 1'b1, iso_en: 1'b1, save: 1'b0, restore: 1'b0};
         ST_OFF:     c = '{pwr_en: 1'b0, iso_en: 1'b1, save: 1'b0, restore: 1'b0};
         ST_PWR_UP:  c = '{pwr_en: 1'b1, iso_en: 1'b1, save: 1'b0, restore: 1'b0};
         ST_RESTORE: c = '{pwr_en: 1'b1, iso_en: 1'b1, save: 1'b0, restore: 1'b1};
         default:    c = CTRL_ON;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_pwr_ramp_cnt.sv
// -----------------------------------------------------------------------------
// alu_pwr_ramp_cnt
// Power-ramp down-counter. Loads on request, decrements while enabled and
// saturates at zero (never wraps).
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load counter with load_val (has priority over dec)
//   load_val    value loaded on load
//   dec         decrement by one if non-zero
//   zero        counter currently equals zero
// -----------------------------------------------------------------------------
module alu_pwr_ramp_cnt
   import alu_pwr_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [RAMP_W-1:0] load_val,
   input  logic              dec,
   output logic              zero
);

   logic [RAMP_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// -----------------------------------------------------------------------------
// alu_pwr_ctrl
// Power-sequencing FSM for the gated ALU domain. Orders save -> isolate ->
// power-off on sleep, and power-up -> ramp -> restore on wake. Gates upstream
// operation issue through op_gnt.
//   clk, rst_n  clock and asynchronous active-low reset (forces ON)
//   sleep_req   level request to power the domain down
//   op_req      upstream operation pending; wakes the domain, blocks sleep
//   alu_busy    ALU busy, only considered in ON
//   alu_pwr_en  domain power enable          (registered)
//   iso_en      output isolation enable      (registered)
//   save        retention save pulse         (registered)
//   restore     retention restore pulse      (registered)
//   op_gnt      upstream may issue start this cycle
//   pwr_state   current state code, for status
// -----------------------------------------------------------------------------
module alu_pwr_ctrl
   import alu_pwr_pkg::*;
#(
   parameter int RAMP_CYCLES = 4   // legal range 1..255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sleep_req,
   input  logic                   op_req,
   input  logic                   alu_busy,
   output logic                   alu_pwr_en,
   output logic                   iso_en,
   output logic                   save,
   output logic                   restore,
   output logic                   op_gnt,
   output logic [PWR_STATE_W-1:0] pwr_state
);

   localparam logic [RAMP_W-1:0] RAMP_LOAD = RAMP_W'(RAMP_CYCLES - 1);

   pwr_state_e state;
   pwr_state_e next_state;
   pwr_ctrl_t  ctrl;
   logic       sleep_ok;
   logic       wake;
   logic       ramp_load;
   logic       ramp_dec;
   logic       ramp_zero;

   // op_req has priority over sleep_req.
   assign sleep_ok = sleep_req && !op_req;
   assign wake     = op_req || !sleep_req;

   assign ramp_load = (state == ST_OFF) && wake;
   assign ramp_dec  = (state == ST_PWR_UP);

   alu_pwr_ramp_cnt u_ramp_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ramp_load),
      .load_val (RAMP_LOAD),
      .dec      (ramp_dec),
      .zero     (ramp_zero)
   );

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = ST_ON;
      case (state)
         ST_ON:      next_state = (sleep_ok && !alu_busy) ? ST_SAVE : ST_ON;
         ST_SAVE:    next_state = ST_ISO;
         ST_ISO:     next_state = ST_OFF;
         ST_OFF:     next_state = wake ? ST_PWR_UP : ST_OFF;
         ST_PWR_UP:  next_state = ramp_zero ? ST_RESTORE : ST_PWR_UP;
         ST_RESTORE: next_state = ST_ON;
         default:    next_state = ST_ON;
      endcase
   end

   // Controls are flopped from the decode of next_state, so they change on the
   // same edge as the state register and carry no decode glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ON;
         ctrl  <= CTRL_ON;
      end else begin
         state <= next_state;
         ctrl  <= decode_ctrl(next_state);
      end
   end

   assign alu_pwr_en = ctrl.pwr_en;
   assign iso_en     = ctrl.iso_en;
   assign save       = ctrl.save;
   assign restore    = ctrl.restore;
   assign pwr_state  = state;

   // A sleep decision closes the grant in the same cycle.
   assign op_gnt = (state == ST_ON) && !alu_busy && !sleep_ok;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_pwr_ctrl
// Directed bench for alu_pwr_ctrl with RAMP_CYCLES = 4. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_pwr_ctrl;

   // Expected {alu_pwr_en, iso_en, save, restore, pwr_state[2:0]}
   localparam logic [6:0] E_ON      = 7'b1000_000;
   localparam logic [6:0] E_SAVE    = 7'b1010_001;
   localparam logic [6:0] E_ISO     = 7'b1100_010;
   localparam logic [6:0] E_OFF     = 7'b0100_011;
   localparam logic [6:0] E_PWR_UP  = 7'b1100_100;
   localparam logic [6:0] E_RESTORE = 7'b1101_101;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sleep_req;
   logic       op_req;
   logic       alu_busy;
   logic       alu_pwr_en;
   logic       iso_en;
   logic       save;
   logic       restore;
   logic       op_gnt;
   logic [2:0] pwr_state;
   logic [6:0] obs;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign obs = {alu_pwr_en, iso_en, save, restore, pwr_state};

   alu_pwr_ctrl #(.RAMP_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sleep_req  (sleep_req),
      .op_req     (op_req),
      .alu_busy   (alu_busy),
      .alu_pwr_en (alu_pwr_en),
      .iso_en     (iso_en),
      .save       (save),
      .restore    (restore),
      .op_gnt     (op_gnt),
      .pwr_state  (pwr_state)
   );

   // save and restore must never be high together.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         n_total++;
         if ((save & restore) !== 1'b0)
            $display("FAIL save_restore_overlap save=%b restore=%b want not both 1", save, restore);
         else
            n_pass++;
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; sleep_req = 1'b0; op_req = 1'b0; alu_busy = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if (obs !== E_ON) $display("FAIL reset_state got=%b want=%b", obs, E_ON);
      else n_pass++;
      n_total++;
      if (op_gnt !== 1'b1) $display("FAIL reset_gnt got=%b want=1", op_gnt);
      else n_pass++;
      alu_busy = 1'b1;
      #1;
      n_total++;
      if (op_gnt !== 1'b0) $display("FAIL reset_gnt_busy got=%b want=0", op_gnt);
      else n_pass++;
      alu_busy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if ({obs, op_gnt} !== {E_ON, 1'b1})
         $display("FAIL post_reset got=%b/%b want=%b/1", obs, op_gnt, E_ON);
      else n_pass++;
   endtask

   task automatic test_sleep_busy();
      logic [6:0] seq [0:3];
      seq = '{E_SAVE, E_ISO, E_OFF, E_OFF};
      sleep_req = 1'b1; alu_busy = 1'b1;
      #1;
      n_total++;
      if (op_gnt !== 1'b0) $display("FAIL busy_gnt got=%b want=0", op_gnt);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_total++;
         if (obs !== E_ON) $display("FAIL busy_hold[%0d] got=%b want=%b", i, obs, E_ON);
         else n_pass++;
      end
      alu_busy = 1'b0;
      #1;
      n_total++;
      if (op_gnt !== 1'b0) $display("FAIL sleep_gnt got=%b want=0", op_gnt);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_total++;
         if (obs !== seq[i]) $display("FAIL sleep_seq[%0d] got=%b want=%b", i, obs, seq[i]);
         else n_pass++;
      end
   endtask

   // op_req pulse in OFF while sleep_req stays high: wake, then re-sleep.
   task automatic test_wake();
      logic [6:0] seq [0:7];
      seq = '{E_PWR_UP, E_PWR_UP, E_PWR_UP, E_RESTORE, E_ON, E_SAVE, E_ISO, E_OFF};
      op_req = 1'b1;
      @(negedge clk);
      n_total++;
      if (obs !== E_PWR_UP) $display("FAIL wake_entry got=%b want=%b", obs, E_PWR_UP);
      else n_pass++;
      op_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_total++;
         if (obs !== seq[i]) $display("FAIL wake_seq[%0d] got=%b want=%b", i, obs, seq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_op_priority();
      logic [6:0] seq [0:5];
      seq = '{E_PWR_UP, E_PWR_UP, E_PWR_UP, E_PWR_UP, E_RESTORE, E_ON};
      sleep_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_total++;
         if (obs !== seq[i]) $display("FAIL prio_wake[%0d] got=%b want=%b", i, obs, seq[i]);
         else n_pass++;
      end
      n_total++;
      if (op_gnt !== 1'b1) $display("FAIL prio_idle_gnt got=%b want=1", op_gnt);
      else n_pass++;
      sleep_req = 1'b1; op_req = 1'b1;
      #1;
      n_total++;
      if (op_gnt !== 1'b1) $display("FAIL prio_gnt got=%b want=1", op_gnt);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if ({obs, op_gnt} !== {E_ON, 1'b1})
            $display("FAIL prio_hold[%0d] got=%b/%b want=%b/1", i, obs, op_gnt, E_ON);
         else n_pass++;
      end
      op_req = 1'b0;
      #1;
      n_total++;
      if (op_gnt !== 1'b0) $display("FAIL prio_drop_gnt got=%b want=0", op_gnt);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (obs !== E_SAVE) $display("FAIL prio_save got=%b want=%b", obs, E_SAVE);
      else n_pass++;
   endtask

   // Entered in SAVE; sleep_req toggles must not abort the down-sequence.
   task automatic test_sleep_toggle();
      sleep_req = 1'b0;
      @(negedge clk);
      n_total++;
      if ({obs, op_gnt} !== {E_ISO, 1'b0})
         $display("FAIL toggle_iso got=%b/%b want=%b/0", obs, op_gnt, E_ISO);
      else n_pass++;
      sleep_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_total++;
         if (obs !== E_OFF) $display("FAIL toggle_off[%0d] got=%b want=%b", i, obs, E_OFF);
         else n_pass++;
      end
      sleep_req = 1'b0;
      @(negedge clk);
      n_total++;
      if (obs !== E_PWR_UP) $display("FAIL toggle_wake got=%b want=%b", obs, E_PWR_UP);
      else n_pass++;
   endtask

   // Entered in the first PWR_UP cycle; sleep during ramp completes to ON first.
   task automatic test_resleep();
      logic [6:0] seq [0:7];
      seq = '{E_PWR_UP, E_PWR_UP, E_PWR_UP, E_RESTORE, E_ON, E_SAVE, E_ISO, E_OFF};
      sleep_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_total++;
         if (obs !== seq[i]) $display("FAIL resleep_seq[%0d] got=%b want=%b", i, obs, seq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_pwrup();
      sleep_req = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if (obs !== E_PWR_UP) $display("FAIL rst_pre got=%b want=%b", obs, E_PWR_UP);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (obs !== E_ON) $display("FAIL rst_async got=%b want=%b", obs, E_ON);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_total++;
         if (obs !== E_ON) $display("FAIL rst_after[%0d] got=%b want=%b", i, obs, E_ON);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_sleep_busy();
      test_wake();
      test_op_priority();
      test_sleep_toggle();
      test_resleep();
      test_reset_mid_pwrup();
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
